// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC execution sequencer.
// Micro-command field offsets, memory size codes and halt reason codes.
package npc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_INST,
    S_DECODE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_e;

  localparam int MC_REGEN   = 12;
  localparam int MC_PCJEN   = 11;
  localparam int MC_PCREN   = 10;
  localparam int MC_MWEN_HI = 9;
  localparam int MC_MWEN_LO = 8;
  localparam int MC_MREN_HI = 7;
  localparam int MC_MREN_LO = 6;

  localparam logic [1:0] MWEN_NONE = 2'd0;
  localparam logic [1:0] MWEN_B    = 2'd1;
  localparam logic [1:0] MWEN_H    = 2'd2;
  localparam logic [1:0] MWEN_W    = 2'd3;

  localparam logic [1:0] MREN_NONE = 2'd0;
  localparam logic [1:0] MREN_B    = 2'd1;
  localparam logic [1:0] MREN_H    = 2'd2;
  localparam logic [1:0] MREN_W    = 2'd3;

  localparam logic [1:0] HALT_EBREAK  = 2'd0;
  localparam logic [1:0] HALT_ILLEGAL = 2'd1;
  localparam logic [1:0] HALT_TIMEOUT = 2'd2;
  localparam logic [1:0] HALT_MEMCONF = 2'd3;

endpackage

// File: rtl/npc_wait_timer.sv
// Wait-cycle counter for handshake states; expired flags the cycle that completes
// 2**W-1 consecutive enabled cycles without a clear.
module npc_wait_timer #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] CNT_MAX  = '1;
  localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Depends only on the registered count so the FSM can use it without a comb loop.
  assign expired = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/npc_exec_sequencer.sv
// Multi-cycle control FSM: fetch, decode, optional memory access, writeback.
// Drives IFU/LSU valid-ready handshakes and single-cycle RF/PC commit strobes.
module npc_exec_sequencer
  import npc_pkg::*;
#(
  parameter int MICRO_LEN = 13,
  parameter int INST_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 if_req_valid,
  input  logic                 if_req_ready,
  input  logic                 if_rsp_valid,
  input  logic [INST_W-1:0]    if_rsp_inst,
  output logic [INST_W-1:0]    inst_q,
  input  logic [MICRO_LEN-1:0] micro_cmd,
  input  logic                 lut_hit,
  input  logic                 is_ebreak,
  output logic                 lsu_req_valid,
  input  logic                 lsu_req_ready,
  output logic                 lsu_we,
  output logic [1:0]           lsu_size,
  input  logic                 lsu_rsp_valid,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic                 pc_jump,
  output logic                 halted,
  output logic [1:0]           halt_code
);

  state_e                 state_q, state_d;
  logic [INST_W-1:0]      inst_d;
  logic [MICRO_LEN-1:0]   mc_q, mc_d;
  logic [1:0]             halt_code_q, halt_code_d;

  logic                   tmr_clr;
  logic                   tmr_en;
  logic                   tmr_expired;

  logic [1:0]             dec_mwen, dec_mren;
  logic [1:0]             mc_mwen, mc_mren;
  logic                   unused_mc_bits;

  assign dec_mwen = micro_cmd[MC_MWEN_HI:MC_MWEN_LO];
  assign dec_mren = micro_cmd[MC_MREN_HI:MC_MREN_LO];
  assign mc_mwen  = mc_q[MC_MWEN_HI:MC_MWEN_LO];
  assign mc_mren  = mc_q[MC_MREN_HI:MC_MREN_LO];

  // PCREN, ALUOP and IMM belong to the datapath; the sequencer only carries them.
  assign unused_mc_bits = ^{mc_q[MC_PCREN], mc_q[MC_MREN_LO-1:0]};

  assign tmr_en  = (state_q == S_FETCH)   || (state_q == S_WAIT_INST) ||
                   (state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT);
  assign tmr_clr = (state_d != state_q);

  npc_wait_timer #(
    .W (TIMEOUT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    mc_d        = mc_q;
    halt_code_d = halt_code_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (if_req_ready) begin
          state_d = S_WAIT_INST;
        end else if (tmr_expired) begin
          state_d     = S_HALT;
          halt_code_d = HALT_TIMEOUT;
        end
      end
      S_WAIT_INST: begin
        if (if_rsp_valid) begin
          inst_d  = if_rsp_inst;
          state_d = S_DECODE;
        end else if (tmr_expired) begin
          state_d     = S_HALT;
          halt_code_d = HALT_TIMEOUT;
        end
      end
      S_DECODE: begin
        mc_d = micro_cmd;
        if (!lut_hit) begin
          state_d     = S_HALT;
          halt_code_d = HALT_ILLEGAL;
        end else if (is_ebreak) begin
          state_d     = S_HALT;
          halt_code_d = HALT_EBREAK;
        end else if ((dec_mwen != MWEN_NONE) && (dec_mren != MREN_NONE)) begin
          state_d     = S_HALT;
          halt_code_d = HALT_MEMCONF;
        end else if ((dec_mwen | dec_mren) != 2'b00) begin
          state_d = S_MEM_REQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_REQ: begin
        if (lsu_req_ready) begin
          state_d = S_MEM_WAIT;
        end else if (tmr_expired) begin
          state_d     = S_HALT;
          halt_code_d = HALT_TIMEOUT;
        end
      end
      S_MEM_WAIT: begin
        if (lsu_rsp_valid) begin
          state_d = S_WB;
        end else if (tmr_expired) begin
          state_d     = S_HALT;
          halt_code_d = HALT_TIMEOUT;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of registered state so reset clears them asynchronously.
  always_comb begin
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_we        = 1'b0;
    lsu_size      = 2'b00;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    pc_jump       = 1'b0;
    halted        = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if_req_valid = 1'b1;
      end
      S_MEM_REQ: begin
        lsu_req_valid = 1'b1;
        lsu_we        = (mc_mwen != MWEN_NONE);
        lsu_size      = (mc_mwen != MWEN_NONE) ? mc_mwen : mc_mren;
      end
      S_WB: begin
        rf_we   = mc_q[MC_REGEN];
        pc_we   = 1'b1;
        pc_jump = mc_q[MC_PCJEN];
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign halt_code = halt_code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      inst_q      <= '0;
      mc_q        <= '0;
      halt_code_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      mc_q        <= mc_d;
      halt_code_q <= halt_code_d;
    end
  end

endmodule
